// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and types for the UART receive controller
//
// Purpose : receiver error codes, handshake FSM state type and default
//           sizing for uart_rx_ctrl and its FIFO.
// Ports   : none (package).
package uart_pkg;

  // Receiver error codes carried on rx_err alongside rx_err_stb.
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_PARITY = 2'd1;
  localparam logic [1:0] ERR_STOP   = 2'd2;

  // Default sizing.
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;

  // Receiver handshake state.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver-side and consumer-side handshake bundle
//
// Purpose : groups the byte handshake from the UART receiver (rx_*) and the
//           valid/ready stream toward the command decoder (m_*).
// Signals : rx_data/rx_valid/rx_err/rx_err_stb/m_ready driven by master,
//           rx_ack/m_data/m_valid driven by slave (the controller).
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] rx_err;
  logic       rx_err_stb;
  logic       rx_ack;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  // Environment side: the receiver plus the consumer.
  modport master (
    output rx_data, rx_valid, rx_err, rx_err_stb, m_ready,
    input  rx_ack, m_data, m_valid
  );

  // Controller side.
  modport slave (
    input  rx_data, rx_valid, rx_err, rx_err_stb, m_ready,
    output rx_ack, m_data, m_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose : DEPTH-entry storage with naturally wrapping pointers.
// Ports   : i_clk, i_rst_n (async, active low)
//           i_push/i_data  write request; accepted when not full or when a
//                          pop is accepted in the same cycle
//           i_pop          read request; ignored when empty
//           o_data         head entry (0 while empty)
//           o_full, o_empty, o_level  occupancy status
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);
  import uart_pkg::*;

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_FULL);
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rptr];
  assign o_level = r_level;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive path sequencer, byte buffer and error counters
//
// Purpose : completes the receiver's level handshake, buffers accepted bytes
//           for the command decoder, counts parity/stop errors and flags
//           bytes dropped on a full buffer.
// Ports   : i_clk, i_rst_n   clock, async active-low reset
//           bus (slave)      rx_* from the receiver, m_* to the consumer
//           i_clr            synchronous clear of counters and overflow flag
//           o_par_cnt        saturating parity error count
//           o_stop_cnt       saturating stop error count
//           o_ovf            sticky dropped-byte flag
//           o_level          FIFO occupancy
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  uart_rx_ctrl_if.slave          bus,
  input  logic                   i_clr,
  output logic [CNT_W-1:0]       o_par_cnt,
  output logic [CNT_W-1:0]       o_stop_cnt,
  output logic                   o_ovf,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  rx_state_t        r_state;
  logic             r_rx_ack;
  logic [CNT_W-1:0] r_par_cnt;
  logic [CNT_W-1:0] r_stop_cnt;
  logic             r_ovf;

  logic             w_capture;
  logic             w_pop_ok;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;

  // One byte is taken per rx_valid assertion: only in IDLE.
  assign w_capture = (r_state == IDLE) && bus.rx_valid;
  assign w_pop_ok  = bus.m_ready && !w_empty;
  // The receiver is never stalled; a byte with nowhere to go is discarded.
  assign w_drop    = w_capture && w_full && !w_pop_ok;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_capture),
    .i_data  (bus.rx_data),
    .i_pop   (bus.m_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // Handshake FSM; rx_ack is the registered image of the ACK state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_rx_ack <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.rx_valid) begin
            r_state  <= ACK;
            r_rx_ack <= 1'b1;
          end
        end
        ACK: begin
          if (!bus.rx_valid) begin
            r_state  <= IDLE;
            r_rx_ack <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_rx_ack <= 1'b0;
        end
      endcase
    end
  end

  // Error statistics; clear wins over any same-cycle increment or set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_cnt  <= '0;
      r_stop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (i_clr) begin
      r_par_cnt  <= '0;
      r_stop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (bus.rx_err_stb && (bus.rx_err == ERR_PARITY) && (r_par_cnt != CNT_MAX)) begin
        r_par_cnt <= r_par_cnt + CNT_W'(1);
      end
      if (bus.rx_err_stb && (bus.rx_err == ERR_STOP) && (r_stop_cnt != CNT_MAX)) begin
        r_stop_cnt <= r_stop_cnt + CNT_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.rx_ack  = r_rx_ack;
  assign bus.m_data  = w_head;
  assign bus.m_valid = !w_empty;
  assign o_par_cnt   = r_par_cnt;
  assign o_stop_cnt  = r_stop_cnt;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  logic clr;

  uart_rx_ctrl_if ifc ();
  uart_rx_ctrl_if ifc2 ();

  logic [7:0] par_cnt, stop_cnt;
  logic       ovf;
  logic [3:0] level;
  logic [1:0] par2, stop2;
  logic       ovf2;
  logic [3:0] level2;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (ifc.slave),
    .i_clr      (clr),
    .o_par_cnt  (par_cnt),
    .o_stop_cnt (stop_cnt),
    .o_ovf      (ovf),
    .o_level    (level)
  );

  // Narrow-counter copy sharing the stimulus, consumer always ready.
  assign ifc2.rx_data    = ifc.rx_data;
  assign ifc2.rx_valid   = ifc.rx_valid;
  assign ifc2.rx_err     = ifc.rx_err;
  assign ifc2.rx_err_stb = ifc.rx_err_stb;
  assign ifc2.m_ready    = 1'b1;

  uart_rx_ctrl #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (ifc2.slave),
    .i_clr      (clr),
    .o_par_cnt  (par2),
    .o_stop_cnt (stop2),
    .o_ovf      (ovf2),
    .o_level    (level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queue, ack follows rx_valid one cycle late,
  // a byte is taken on the first cycle rx_valid is seen with ack low.
  logic [7:0] q[$];
  bit exp_ack = 0;
  bit exp_ovf = 0;
  int exp_par = 0, exp_stop = 0, exp_par2 = 0, exp_stop2 = 0;

  always @(posedge clk) begin
    bit pop, cap, lost;
    if (!rst_n) begin
      q.delete();
      exp_ack = 0; exp_ovf = 0;
      exp_par = 0; exp_stop = 0; exp_par2 = 0; exp_stop2 = 0;
    end else begin
      pop  = ifc.m_ready && (q.size() > 0);
      cap  = ifc.rx_valid && !exp_ack;
      lost = 0;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(ifc.rx_data);
        else lost = 1;
      end
      exp_ack = ifc.rx_valid;
      if (clr) begin
        exp_par = 0; exp_stop = 0; exp_par2 = 0; exp_stop2 = 0; exp_ovf = 0;
      end else begin
        if (ifc.rx_err_stb && ifc.rx_err == 2'd1) begin
          if (exp_par < 255) exp_par++;
          if (exp_par2 < 3) exp_par2++;
        end
        if (ifc.rx_err_stb && ifc.rx_err == 2'd2) begin
          if (exp_stop < 255) exp_stop++;
          if (exp_stop2 < 3) exp_stop2++;
        end
        if (lost) exp_ovf = 1;
      end
    end
    #1;
    chk("ack", ifc.rx_ack, exp_ack);
    chk("m_valid", ifc.m_valid, q.size() != 0);
    chk("level", level, q.size());
    if (q.size() != 0) chk("m_data", ifc.m_data, q[0]);
    chk("par_cnt", par_cnt, exp_par);
    chk("stop_cnt", stop_cnt, exp_stop);
    chk("ovf", ovf, exp_ovf);
    chk("par_cnt_w2", par2, exp_par2);
    chk("stop_cnt_w2", stop2, exp_stop2);
    chk("ovf_w2", ovf2, 0);
    chk("ack_w2", ifc2.rx_ack, exp_ack);
  end

  // Present one byte, hold until acked, release. Returns cycles to ack.
  task automatic send(input logic [7:0] d, output int lat);
    lat = 0;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = d;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ifc.rx_ack) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 0, 1);
    ifc.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [1:0] e);
    ifc.rx_err     = e;
    ifc.rx_err_stb = 1'b1;
    @(negedge clk);
    ifc.rx_err_stb = 1'b0;
    ifc.rx_err     = 2'd0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic drain(input int n);
    ifc.m_ready = 1'b1;
    repeat (n) @(negedge clk);
    ifc.m_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] exp_list [8];
    rst_n = 1'b0;
    clr = 1'b0;
    ifc.rx_data = 8'h00;
    ifc.rx_valid = 1'b0;
    ifc.rx_err = 2'd0;
    ifc.rx_err_stb = 1'b0;
    ifc.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ifc.rx_ack, 0);
    chk("rst_m_valid", ifc.m_valid, 0);
    chk("rst_m_data", ifc.m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte.
    send(8'hA5, lat);
    chk("single_ack_lat", lat, 1);
    chk("single_m_valid", ifc.m_valid, 1);
    chk("single_m_data", ifc.m_data, 8'hA5);
    chk("single_level", level, 1);
    drain(1);
    chk("single_drained", level, 0);

    // Fill and overflow.
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), lat);
      chk("fill_acked", lat, 1);
    end
    chk("fill_level", level, 8);
    chk("fill_ovf", ovf, 1);
    ifc.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("fill_order", ifc.m_data, i);
      @(negedge clk);
    end
    ifc.m_ready = 1'b0;
    chk("fill_empty", level, 0);
    chk("fill_m_valid", ifc.m_valid, 0);
    pulse_clr();
    chk("clr_ovf", ovf, 0);

    // Simultaneous push and pop at full.
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), lat);
    chk("sim_full", level, 8);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'h55;
    ifc.m_ready  = 1'b1;
    @(negedge clk);
    ifc.m_ready  = 1'b0;
    chk("sim_ack", ifc.rx_ack, 1);
    chk("sim_level", level, 8);
    chk("sim_no_ovf", ovf, 0);
    ifc.rx_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) exp_list[i] = 8'h11 + 8'(i);
    exp_list[7] = 8'h55;
    ifc.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("sim_order", ifc.m_data, exp_list[i]);
      @(negedge clk);
    end
    ifc.m_ready = 1'b0;

    // Error counters.
    repeat (3) strobe(2'd1);
    repeat (2) strobe(2'd2);
    strobe(2'd0);
    strobe(2'd3);
    @(negedge clk);
    chk("err_par", par_cnt, 3);
    chk("err_stop", stop_cnt, 2);
    chk("err_par_w2", par2, 3);
    pulse_clr();
    repeat (5) strobe(2'd1);
    @(negedge clk);
    chk("sat_par_w2", par2, 3);
    chk("sat_par_w8", par_cnt, 5);

    // clr beats a same-cycle strobe and a same-cycle drop.
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), lat);
    ifc.rx_valid   = 1'b1;
    ifc.rx_data    = 8'hEE;
    clr            = 1'b1;
    ifc.rx_err     = 2'd1;
    ifc.rx_err_stb = 1'b1;
    @(negedge clk);
    clr            = 1'b0;
    ifc.rx_err_stb = 1'b0;
    ifc.rx_err     = 2'd0;
    chk("clr_pri_par", par_cnt, 0);
    chk("clr_pri_ovf", ovf, 0);
    chk("clr_pri_level", level, 8);
    ifc.rx_valid = 1'b0;
    @(negedge clk);
    drain(8);

    // Asynchronous reset mid-ACK.
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i), lat);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = 8'h44;
    @(negedge clk);
    chk("arst_pre_level", level, 4);
    chk("arst_pre_ack", ifc.rx_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", ifc.rx_ack, 0);
    chk("arst_m_valid", ifc.m_valid, 0);
    chk("arst_level", level, 0);
    ifc.rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C, lat);
    chk("arst_after_lat", lat, 1);
    chk("arst_after_level", level, 1);
    chk("arst_after_data", ifc.m_data, 8'h3C);
    drain(1);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (ifc.rx_valid && ifc.rx_ack && $urandom_range(0, 3) != 0) begin
        ifc.rx_valid = 1'b0;
      end else if (!ifc.rx_valid && !ifc.rx_ack && $urandom_range(0, 2) == 0) begin
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'($urandom);
      end
      if (c < 2000) ifc.m_ready = ($urandom_range(0, 3) == 0);
      else          ifc.m_ready = ($urandom_range(0, 3) != 0);
      ifc.rx_err_stb = ($urandom_range(0, 3) == 0);
      ifc.rx_err     = 2'($urandom_range(0, 3));
      clr            = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    ifc.rx_valid   = 1'b0;
    ifc.rx_err_stb = 1'b0;
    ifc.m_ready    = 1'b0;
    clr            = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
